// File: rtl/cdreq_issue_unit_pkg.sv
// Shared encodings for the cdreq issue unit: cache request opcodes, cache
// response codes, issue FSM states and the legal-opcode check.
package cdreq_issue_unit_pkg;

    localparam int CDREQ_OP_W  = 3;
    localparam int CURSP_RSP_W = 2;

    localparam logic [CDREQ_OP_W-1:0] CDREQ_RD  = 3'd0;
    localparam logic [CDREQ_OP_W-1:0] CDREQ_RFO = 3'd1;
    localparam logic [CDREQ_OP_W-1:0] CDREQ_WB  = 3'd2;
    localparam logic [CDREQ_OP_W-1:0] CDREQ_MD  = 3'd3;

    localparam logic [CURSP_RSP_W-1:0] CURSP_OKAY  = 2'd0;
    localparam logic [CURSP_RSP_W-1:0] CURSP_ERROR = 2'd1;

    typedef enum logic [1:0] {
        CDISS_IDLE = 2'd0,
        CDISS_SEND = 2'd1,
        CDISS_WAIT = 2'd2,
        CDISS_RESP = 2'd3
    } cdiss_state_t;

    // Opcodes 0-3 are the only ones the cache understands; 4-7 are rejected locally.
    function automatic logic cdreq_op_legal(input logic [CDREQ_OP_W-1:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/cdiss_fifo.sv
// Small synchronous FIFO buffering processor requests ahead of the issue FSM.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module cdiss_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Advance the read/write pointers on accepted pushes and pops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage array; contents need no reset because empty masks stale entries.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cdreq_issue_unit.sv
// Issues buffered processor requests to the cache one at a time, returns the
// matching cache response, rejects illegal opcodes and times out hung requests.
// A timed-out transaction leaves drop_pending set so its late response is
// swallowed before any new request may be issued.
module cdreq_issue_unit
    import cdreq_issue_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   preq_valid,
    output logic                   preq_ready,
    input  logic [2:0]             preq_op,
    input  logic [ADDR_WIDTH-1:0]  preq_addr,
    input  logic [DATA_WIDTH-1:0]  preq_data,
    output logic                   prsp_valid,
    input  logic                   prsp_ready,
    output logic [1:0]             prsp_rsp,
    output logic [DATA_WIDTH-1:0]  prsp_data,
    output logic                   cdreq_valid,
    input  logic                   cdreq_ready,
    output logic [2:0]             cdreq_op,
    output logic [ADDR_WIDTH-1:0]  cdreq_addr,
    output logic [DATA_WIDTH-1:0]  cdreq_data,
    input  logic                   cursp_valid,
    output logic                   cursp_ready,
    input  logic [1:0]             cursp_rsp,
    input  logic [DATA_WIDTH-1:0]  cursp_data
);

    localparam int ENTRY_W = CDREQ_OP_W + ADDR_WIDTH + DATA_WIDTH;
    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    cdiss_state_t state;
    cdiss_state_t state_next;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    logic [CDREQ_OP_W-1:0] head_op;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    logic [TIMER_W-1:0] timer;
    logic               drop_pending;
    logic               drop_clear;

    logic set_illegal;
    logic capture_rsp;
    logic set_timeout;
    logic timer_clr;
    logic timer_inc;

    assign wr_entry  = {preq_op, preq_addr, preq_data};
    assign head_op   = rd_entry[ENTRY_W-1 -: CDREQ_OP_W];
    assign head_addr = rd_entry[DATA_WIDTH +: ADDR_WIDTH];
    assign head_data = rd_entry[DATA_WIDTH-1:0];

    assign preq_ready  = !fifo_full;
    assign fifo_push   = preq_valid && !fifo_full;
    assign cdreq_valid = (state == CDISS_SEND);
    assign prsp_valid  = (state == CDISS_RESP);
    assign cursp_ready = (state == CDISS_WAIT) || drop_pending;
    assign drop_clear  = drop_pending && cursp_valid;

    cdiss_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Issue FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CDISS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the one-cycle control strobes for the datapath.
    always_comb begin
        state_next  = state;
        fifo_pop    = 1'b0;
        set_illegal = 1'b0;
        capture_rsp = 1'b0;
        set_timeout = 1'b0;
        timer_clr   = 1'b0;
        timer_inc   = 1'b0;
        case (state)
            CDISS_IDLE: begin
                if (!fifo_empty && !drop_pending) begin
                    fifo_pop = 1'b1;
                    if (cdreq_op_legal(head_op)) begin
                        state_next = CDISS_SEND;
                    end else begin
                        set_illegal = 1'b1;
                        state_next  = CDISS_RESP;
                    end
                end
            end
            CDISS_SEND: begin
                if (cdreq_ready) begin
                    timer_clr  = 1'b1;
                    state_next = CDISS_WAIT;
                end
            end
            CDISS_WAIT: begin
                if (cursp_valid) begin
                    capture_rsp = 1'b1;
                    state_next  = CDISS_RESP;
                end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
                    set_timeout = 1'b1;
                    state_next  = CDISS_RESP;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            CDISS_RESP: begin
                if (prsp_ready) begin
                    state_next = CDISS_IDLE;
                end
            end
            default: begin
                state_next = CDISS_IDLE;
            end
        endcase
    end

    // Request/response payload registers, wait timer and late-response drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cdreq_op     <= '0;
            cdreq_addr   <= '0;
            cdreq_data   <= '0;
            prsp_rsp     <= '0;
            prsp_data    <= '0;
            timer        <= '0;
            drop_pending <= 1'b0;
        end else begin
            if (fifo_pop) begin
                cdreq_op   <= head_op;
                cdreq_addr <= head_addr;
                cdreq_data <= head_data;
            end
            if (set_illegal || set_timeout) begin
                prsp_rsp  <= CURSP_ERROR;
                prsp_data <= '0;
            end else if (capture_rsp) begin
                prsp_rsp  <= cursp_rsp;
                prsp_data <= cursp_data;
            end
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + TIMER_W'(1);
            end
            if (set_timeout) begin
                drop_pending <= 1'b1;
            end else if (drop_clear) begin
                drop_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdreq_issue_unit.sv
// Self-checking bench for cdreq_issue_unit: directed scenarios followed by a
// randomized run checked against a transaction-level model of the unit.
module tb_cdreq_issue_unit;
    import cdreq_issue_unit_pkg::*;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          preq_valid;
    logic          preq_ready;
    logic [2:0]    preq_op;
    logic [AW-1:0] preq_addr;
    logic [DW-1:0] preq_data;
    logic          prsp_valid;
    logic          prsp_ready;
    logic [1:0]    prsp_rsp;
    logic [DW-1:0] prsp_data;
    logic          cdreq_valid;
    logic          cdreq_ready;
    logic [2:0]    cdreq_op;
    logic [AW-1:0] cdreq_addr;
    logic [DW-1:0] cdreq_data;
    logic          cursp_valid;
    logic          cursp_ready;
    logic [1:0]    cursp_rsp;
    logic [DW-1:0] cursp_data;

    int check_count = 0;
    int pass_count  = 0;

    typedef struct packed {
        logic [2:0]    op;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    typedef struct packed {
        logic [1:0]    rsp;
        logic [DW-1:0] data;
        logic          timeout;
    } res_t;

    cdreq_issue_unit #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .preq_valid  (preq_valid),
        .preq_ready  (preq_ready),
        .preq_op     (preq_op),
        .preq_addr   (preq_addr),
        .preq_data   (preq_data),
        .prsp_valid  (prsp_valid),
        .prsp_ready  (prsp_ready),
        .prsp_rsp    (prsp_rsp),
        .prsp_data   (prsp_data),
        .cdreq_valid (cdreq_valid),
        .cdreq_ready (cdreq_ready),
        .cdreq_op    (cdreq_op),
        .cdreq_addr  (cdreq_addr),
        .cdreq_data  (cdreq_data),
        .cursp_valid (cursp_valid),
        .cursp_ready (cursp_ready),
        .cursp_rsp   (cursp_rsp),
        .cursp_data  (cursp_data)
    );

    // Free-running clock; inputs change and outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        preq_valid  = 1'b0;
        preq_op     = '0;
        preq_addr   = '0;
        preq_data   = '0;
        prsp_ready  = 1'b0;
        cdreq_ready = 1'b0;
        cursp_valid = 1'b0;
        cursp_rsp   = '0;
        cursp_data  = '0;
    endtask

    task automatic applyReset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkOutput({pfx, "_preq_ready"},  64'(preq_ready),  64'd1);
        checkOutput({pfx, "_prsp_valid"},  64'(prsp_valid),  64'd0);
        checkOutput({pfx, "_cdreq_valid"}, 64'(cdreq_valid), 64'd0);
        checkOutput({pfx, "_cursp_ready"}, 64'(cursp_ready), 64'd0);
        checkOutput({pfx, "_prsp_rsp"},    64'(prsp_rsp),    64'd0);
        checkOutput({pfx, "_prsp_data"},   64'(prsp_data),   64'd0);
        checkOutput({pfx, "_cdreq_op"},    64'(cdreq_op),    64'd0);
        checkOutput({pfx, "_cdreq_addr"},  64'(cdreq_addr),  64'd0);
        checkOutput({pfx, "_cdreq_data"},  64'(cdreq_data),  64'd0);
    endtask

    // Offer one request and hold it until the unit accepts it (bounded).
    task automatic applyStimulus(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n = 0;
        preq_valid = 1'b1;
        preq_op    = op;
        preq_addr  = addr;
        preq_data  = data;
        while (!preq_ready && n < 50) begin
            tick();
            n++;
        end
        if (!preq_ready) checkOutput("push_accept", 64'd0, 64'd1);
        tick();
        preq_valid = 1'b0;
    endtask

    // Acts as a well-behaved cache and processor until one response is taken.
    task automatic serveOne(input logic [DW-1:0] rdata, output logic [1:0] rsp, output logic [DW-1:0] data, output logic [AW-1:0] addr);
        bit got = 0;
        cdreq_ready = 1'b1;
        prsp_ready  = 1'b1;
        rsp  = '1;
        data = '1;
        addr = '1;
        for (int c = 0; c < 40 && !got; c++) begin
            cursp_valid = cursp_ready;
            cursp_rsp   = CURSP_OKAY;
            cursp_data  = rdata;
            if (cdreq_valid) addr = cdreq_addr;
            if (prsp_valid) begin
                rsp = prsp_rsp;
                data = prsp_data;
                got = 1;
            end
            tick();
        end
        if (!got) checkOutput("serve_one_bound", 64'd0, 64'd1);
        cursp_valid = 1'b0;
        prsp_ready  = 1'b0;
        cdreq_ready = 1'b0;
    endtask

    task automatic runRandom();
        req_t cur;
        req_t r;
        req_t e;
        res_t res;
        req_t req_q[$];
        req_t leg_q[$];
        res_t res_q[$];
        bit   have_cur = 0;
        int   total = 40;
        int   pushes_left = 40;
        int   done = 0;
        bit   cache_active = 0;
        int   cache_cnt = 0;
        logic [1:0]    pend_rsp = '0;
        logic [DW-1:0] pend_data = '0;
        int   cyc;
        for (cyc = 0; cyc < 4000 && !(done >= total && pushes_left == 0 && !cache_active); cyc++) begin
            if (!have_cur && pushes_left > 0 && ($urandom % 3) != 0) begin
                cur.op   = (($urandom % 5) == 0) ? 3'(4 + $urandom % 4) : 3'($urandom % 4);
                cur.addr = $urandom;
                cur.data = $urandom;
                have_cur = 1;
            end
            preq_valid  = have_cur;
            preq_op     = cur.op;
            preq_addr   = cur.addr;
            preq_data   = cur.data;
            prsp_ready  = 1'($urandom % 2);
            cdreq_ready = 1'($urandom % 2);
            cursp_valid = 1'b0;
            if (cache_active) begin
                if (cache_cnt == 0) begin
                    cursp_valid = 1'b1;
                    cursp_rsp   = pend_rsp;
                    cursp_data  = pend_data;
                end else begin
                    cache_cnt--;
                end
            end
            if (preq_valid && preq_ready) begin
                req_q.push_back(cur);
                if (cur.op < 3'd4) leg_q.push_back(cur);
                have_cur = 0;
                pushes_left--;
            end
            if (prsp_valid && prsp_ready) begin
                done++;
                if (req_q.size() == 0) begin
                    checkOutput("rnd_spurious_rsp", 64'd1, 64'd0);
                end else begin
                    r = req_q.pop_front();
                    if (r.op >= 3'd4) begin
                        checkOutput("rnd_illegal_rsp",  64'(prsp_rsp),  64'(CURSP_ERROR));
                        checkOutput("rnd_illegal_data", 64'(prsp_data), 64'd0);
                    end else if (res_q.size() == 0) begin
                        checkOutput("rnd_rsp_before_issue", 64'd1, 64'd0);
                    end else begin
                        res = res_q.pop_front();
                        if (res.timeout) begin
                            checkOutput("rnd_timeout_rsp", 64'(prsp_rsp), 64'(CURSP_ERROR));
                        end else begin
                            checkOutput("rnd_rsp",  64'(prsp_rsp),  64'(res.rsp));
                            checkOutput("rnd_data", 64'(prsp_data), 64'(res.data));
                        end
                    end
                end
            end
            if (cdreq_valid && cdreq_ready) begin
                if (leg_q.size() == 0) begin
                    checkOutput("rnd_spurious_issue", 64'd1, 64'd0);
                end else begin
                    e = leg_q.pop_front();
                    checkOutput("rnd_issue_op",   64'(cdreq_op),   64'(e.op));
                    checkOutput("rnd_issue_addr", 64'(cdreq_addr), 64'(e.addr));
                    checkOutput("rnd_issue_data", 64'(cdreq_data), 64'(e.data));
                    res.timeout  = (($urandom % 5) == 0);
                    res.rsp      = (($urandom % 4) == 0) ? CURSP_ERROR : CURSP_OKAY;
                    res.data     = $urandom;
                    res_q.push_back(res);
                    pend_rsp     = res.rsp;
                    pend_data    = res.data;
                    cache_cnt    = res.timeout ? (TIMEOUT + 4 + int'($urandom % 3)) : int'($urandom % 4);
                    cache_active = 1;
                end
            end
            if (cursp_valid && cursp_ready) cache_active = 0;
            tick();
        end
        idleInputs();
        checkOutput("rnd_all_responses", 64'(done), 64'(total));
        checkOutput("rnd_queues_empty", 64'(req_q.size() + leg_q.size() + res_q.size()), 64'd0);
    endtask

    initial begin
        logic [1:0]    rsp;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [1:0]    hold_rsp;
        logic [DW-1:0] hold_data;
        logic [AW-1:0] issued_q[$];
        logic [DW-1:0] got_q[$];
        int seen;
        int accepted;
        int wait_start;
        int cyc;
        bit flag;
        bit flag2;
        bit issued;

        idleInputs();
        rst_n = 1'b0;
        @(negedge clk);
        applyReset(3);
        checkResetOutputs("reset");

        // Single RD with an immediately ready cache: response visible at cycle 4.
        cdreq_ready = 1'b1;
        preq_valid  = 1'b1;
        preq_op     = CDREQ_RD;
        preq_addr   = 32'h40;
        preq_data   = '0;
        seen = -1;
        for (int c = 1; c <= 10 && seen < 0; c++) begin
            tick();
            preq_valid  = 1'b0;
            cursp_valid = cursp_ready;
            cursp_rsp   = CURSP_OKAY;
            cursp_data  = 32'hDEADBEEF;
            if (prsp_valid) seen = c;
        end
        checkOutput("lat_cycle", 64'(seen), 64'd4);
        checkOutput("lat_rsp",   64'(prsp_rsp),  64'(CURSP_OKAY));
        checkOutput("lat_data",  64'(prsp_data), 64'hDEADBEEF);
        cursp_valid = 1'b0;
        prsp_ready  = 1'b1;
        tick();
        prsp_ready  = 1'b0;
        checkOutput("lat_rsp_taken", 64'(prsp_valid), 64'd0);

        // Back-to-back pushes with the cache stalled: one request sits in SEND,
        // four fill the FIFO, the sixth offer is refused.
        cdreq_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            preq_valid = (accepted < 6);
            preq_op    = CDREQ_RD;
            preq_addr  = 32'h100 + 32'(accepted * 4);
            preq_data  = '0;
            if (preq_valid && preq_ready) begin
                tick();
                accepted++;
            end else begin
                tick();
            end
        end
        preq_valid = 1'b0;
        checkOutput("fill_accepted", 64'(accepted), 64'd5);
        checkOutput("fill_full_ready", 64'(preq_ready), 64'd0);
        cdreq_ready = 1'b1;
        prsp_ready  = 1'b1;
        for (int c = 0; c < 80 && got_q.size() < 5; c++) begin
            cursp_valid = cursp_ready;
            cursp_rsp   = CURSP_OKAY;
            if (cdreq_valid) begin
                issued_q.push_back(cdreq_addr);
                cursp_data = cdreq_addr ^ 32'h5A5A0000;
            end
            if (prsp_valid) got_q.push_back(prsp_data);
            tick();
        end
        cursp_valid = 1'b0;
        prsp_ready  = 1'b0;
        cdreq_ready = 1'b0;
        checkOutput("drain_issued", 64'(issued_q.size()), 64'd5);
        checkOutput("drain_resps",  64'(got_q.size()),    64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < issued_q.size()) checkOutput("drain_addr", 64'(issued_q[i]), 64'(32'h100 + 32'(i * 4)));
            if (i < got_q.size())    checkOutput("drain_data", 64'(got_q[i]), 64'((32'h100 + 32'(i * 4)) ^ 32'h5A5A0000));
        end

        // Illegal opcode is answered locally and never reaches the cache.
        cdreq_ready = 1'b1;
        applyStimulus(3'b110, 32'h200, 32'h1234);
        flag = 0;
        seen = 0;
        for (int c = 0; c < 12 && !seen; c++) begin
            if (cdreq_valid) flag = 1;
            if (prsp_valid) begin
                seen = 1;
                checkOutput("illegal_rsp",  64'(prsp_rsp),  64'(CURSP_ERROR));
                checkOutput("illegal_data", 64'(prsp_data), 64'd0);
            end else begin
                tick();
            end
        end
        checkOutput("illegal_seen", 64'(seen), 64'd1);
        checkOutput("illegal_no_issue", 64'(flag), 64'd0);
        prsp_ready = 1'b1;
        tick();
        prsp_ready  = 1'b0;
        cdreq_ready = 1'b0;

        // Cache never answers: error after TIMEOUT cycles, late beat dropped,
        // the queued request waits for that drop.
        applyStimulus(CDREQ_RD, 32'h300, 32'h0);
        applyStimulus(CDREQ_RD, 32'h304, 32'h0);
        cdreq_ready = 1'b1;
        wait_start = -1;
        seen = -1;
        for (cyc = 0; cyc < 40 && seen < 0; cyc++) begin
            if (prsp_valid) begin
                seen = cyc;
            end else begin
                if (cdreq_valid && wait_start < 0) wait_start = cyc + 1;
                tick();
            end
        end
        checkOutput("timeout_cycles", 64'(seen - wait_start), 64'(TIMEOUT));
        checkOutput("timeout_rsp", 64'(prsp_rsp), 64'(CURSP_ERROR));
        checkOutput("timeout_drop_ready", 64'(cursp_ready), 64'd1);
        prsp_ready = 1'b1;
        tick();
        prsp_ready = 1'b0;
        flag = 0;
        for (int c = 0; c < 6; c++) begin
            if (cdreq_valid) flag = 1;
            tick();
        end
        checkOutput("timeout_stall_issue", 64'(flag), 64'd0);
        cursp_valid = 1'b1;
        cursp_rsp   = CURSP_OKAY;
        cursp_data  = 32'hBADBAD00;
        checkOutput("late_ready", 64'(cursp_ready), 64'd1);
        tick();
        cursp_valid = 1'b0;
        serveOne(32'h0000CAFE, rsp, data, addr);
        checkOutput("after_drop_addr", 64'(addr), 64'h304);
        checkOutput("after_drop_rsp",  64'(rsp),  64'(CURSP_OKAY));
        checkOutput("after_drop_data", 64'(data), 64'h0000CAFE);

        // Processor stalls a response for 10 cycles while new requests arrive.
        applyStimulus(CDREQ_WB, 32'h400, 32'h77);
        cdreq_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            cursp_valid = cursp_ready;
            cursp_rsp   = CURSP_OKAY;
            cursp_data  = 32'h1111;
            if (prsp_valid) seen = 1;
            else tick();
        end
        cursp_valid = 1'b0;
        checkOutput("stall_seen", 64'(seen), 64'd1);
        hold_rsp  = prsp_rsp;
        hold_data = prsp_data;
        checkOutput("stall_data", 64'(hold_data), 64'h1111);
        accepted = 0;
        flag  = 0;
        flag2 = 0;
        for (int c = 0; c < 10; c++) begin
            preq_valid = 1'b1;
            preq_op    = CDREQ_RD;
            preq_addr  = 32'h500 + 32'(accepted * 4);
            if (!prsp_valid || prsp_rsp !== hold_rsp || prsp_data !== hold_data) flag = 1;
            if (cdreq_valid) flag2 = 1;
            if (preq_ready) accepted++;
            tick();
        end
        preq_valid = 1'b0;
        checkOutput("stall_payload_changed", 64'(flag), 64'd0);
        checkOutput("stall_issue", 64'(flag2), 64'd0);
        checkOutput("stall_accepted", 64'(accepted), 64'(DEPTH));
        checkOutput("stall_full", 64'(preq_ready), 64'd0);

        // Release, issue the next request, then reset while it waits on the cache.
        prsp_ready = 1'b1;
        tick();
        prsp_ready = 1'b0;
        issued = 0;
        for (int c = 0; c < 10 && !issued; c++) begin
            if (cdreq_valid) issued = 1;
            tick();
        end
        cdreq_ready = 1'b0;
        checkOutput("pre_reset_issue", 64'(issued), 64'd1);
        checkOutput("pre_reset_wait", 64'(cursp_ready), 64'd1);
        applyReset(1);
        checkResetOutputs("midreset");
        cursp_valid = 1'b1;
        cursp_rsp   = CURSP_OKAY;
        flag = 0;
        for (int c = 0; c < 4; c++) begin
            if (cursp_ready || prsp_valid || cdreq_valid) flag = 1;
            tick();
        end
        cursp_valid = 1'b0;
        checkOutput("post_reset_quiet", 64'(flag), 64'd0);

        applyReset(2);
        runRandom();

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
